// File: rtl/fetch_unit_if.sv
// Fetch-to-ROM/decode/execute signal bundle for fetch_unit.
// master = fetch stage, slave = surrounding pipeline (ROM, decode, execute).
interface fetch_unit_if;
  logic [15:0] pc_out;
  logic [15:0] rom_data;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        halted;

  modport master (
    output pc_out, ir, ir_pc, ir_valid, halted,
    input  rom_data, ir_ready, branch_en, branch_target
  );

  modport slave (
    input  pc_out, ir, ir_pc, ir_valid, halted,
    output rom_data, ir_ready, branch_en, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the combinational ROM address and
// registers the fetched word for decode. Define FETCH_HALT_DETECT_EN to stop on HALT_WORD.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   RUN    | fetching one word per cycle whenever ir is empty or consumed
//   HALTED | HALT_WORD was loaded; no more loads until branch or reset
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  logic [15:0] pc;
  logic [15:0] ir_q;
  logic [15:0] ir_pc_q;
  logic        ir_valid_q;
  logic        run;
  logic        load;

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic {RUN, HALTED} state_t;
  state_t state;

  assign run        = (state == RUN);
  assign bus.halted = (state == HALTED);
`else
  logic unused_halt_word;

  assign run              = 1'b1;
  assign bus.halted       = 1'b0;
  assign unused_halt_word = ^HALT_WORD;
`endif

  assign load = run && (!ir_valid_q || bus.ir_ready) && !bus.branch_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      ir_valid_q <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      state      <= RUN;
`endif
    end else if (bus.branch_en) begin
      // A coinciding transfer is already consumed; a stalled word is dropped.
      pc         <= bus.branch_target;
      ir_valid_q <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      state      <= RUN;
`endif
    end else if (load) begin
      ir_q       <= bus.rom_data;
      ir_pc_q    <= pc;
      ir_valid_q <= 1'b1;
`ifdef FETCH_HALT_DETECT_EN
      if (bus.rom_data == HALT_WORD) begin
        state <= HALTED;
      end else begin
        pc <= pc + 16'd1;
      end
`else
      pc         <= pc + 16'd1;
`endif
    end else if (ir_valid_q && bus.ir_ready) begin
      ir_valid_q <= 1'b0;
    end
  end

  assign bus.pc_out   = pc;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction ROM and downstream into decode. Owns the program counter, drives the ROM address combinationally, captures the returned 16-bit word into an instruction register, and hands it to the decoder over a valid/ready handshake. Supports branch redirect from execute and an optional halt-on-opcode mode.

## Interface

- Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_WORD, 16'hFFFF, instruction encoding treated as HALT (only with FETCH_HALT_DETECT_EN).
- Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_out  out  16  current PC; drives the ROM address input.
- rom_data  in  16  ROM word at pc_out, valid in the same cycle (combinational ROM).
- ir  out  16  registered instruction to decode.
- ir_pc  out  16  address the word in ir was fetched from.
- ir_valid  out  1  ir holds an instruction not yet accepted.
- ir_ready  in  1  decoder accepts ir this cycle.
- branch_en  in  1  single-cycle redirect request from execute.
- branch_target  in  16  new PC when branch_en=1.
- halted  out  1  fetch stopped on HALT_WORD (always 0 without the macro).

## Operation

- States: RUN, HALTED. Reset enters RUN.
- load = (state==RUN) && (!ir_valid || ir_ready) && !branch_en.
- On load: ir<=rom_data, ir_pc<=pc_out, ir_valid<=1, pc<=pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
- Transfer (ir_valid && ir_ready) without a new load: ir_valid<=0; ir/ir_pc hold last value.
- Stall (ir_valid && !ir_ready): pc, ir, ir_pc, ir_valid all hold.
- Branch (branch_en=1), highest priority after reset: pc<=branch_target, ir_valid<=0, state<=RUN. A transfer coinciding with branch_en still completes (decoder consumed it); no load occurs that cycle.
- HALT (macro enabled): when a load captures rom_data==HALT_WORD, ir/ir_valid load normally so decode sees it, pc is NOT incremented, state<=HALTED. In HALTED no loads; ir_valid clears on transfer; exit only via branch_en or reset.
- halted = (state==HALTED).

## Timing

- Reset (async assert): pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, state=RUN.
- First rising edge after reset release: ir=ROM[RESET_PC], ir_valid=1, pc=RESET_PC+1.
- Fetch latency 1 cycle (pc_out to ir); throughput 1 instruction/cycle while ir_ready=1.
- Branch: edge with branch_en=1 -> next cycle pc_out=branch_target, ir_valid=0; following edge ir=ROM[target]. Bubble of exactly 1 cycle.
- Reset asserted mid-stall, mid-branch or in HALTED: immediate return to reset values; in-flight ir discarded.
- branch_en while ir_valid && !ir_ready: held instruction is discarded.

## Configuration

- FETCH_HALT_DETECT_EN defined: HALT_WORD detection and HALTED state compiled in as above.
- Undefined: HALTED state absent, HALT_WORD fetched as an ordinary instruction, halted tied to 0.

## Test plan

- Reset release, ir_ready=1, ROM[0..3]=A,B,C,D -> ir=A,B,C,D on consecutive edges, ir_pc=0,1,2,3, ir_valid=1 throughout.
- ir_ready low for 3 cycles while ir=B -> ir=B, ir_pc=1, pc_out=2 held; ir_ready high -> next edge ir=C.
- branch_en=1, branch_target=16'h0100 while ir=C valid -> next cycle ir_valid=0, pc_out=16'h0100; following edge ir=ROM[16'h0100], ir_pc=16'h0100.
- branch_target=16'hFFFF, ir_ready=1 -> ir_pc=16'hFFFF then 16'h0000 (wrap).
- Macro on, ROM[5]=16'hFFFF -> ir=16'hFFFF valid, halted=1, pc_out stays 5, ir_valid=0 after transfer, no further loads; branch_en to 0 -> halted=0, fetch resumes at 0. Macro off -> same program, halted=0, pc_out advances to 6.
- Assert reset asynchronously mid-cycle during a stall -> all outputs at reset values before the next edge.
